// File: rtl/whack_pkg.sv
// Shared types, constants and BCD helpers for the whack-a-LED round controller.
package whack_pkg;

  // Round sequencer states
  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StWait,
    StGap,
    StDone
  } state_e;

  // One BCD digit
  typedef logic [3:0] bcd_digit_t;

  // Fibonacci taps for x^8+x^6+x^5+x^4+1 (bits 7,5,4,3)
  localparam logic [7:0] LfsrTaps = 8'hB8;

  // Two-digit BCD increment, sticks at 99
  function automatic logic [7:0] bcd_inc_sat(input logic [7:0] val);
    bcd_digit_t tens;
    bcd_digit_t units;
    tens  = val[7:4];
    units = val[3:0];
    if (val == 8'h99) return val;
    if (units == 4'd9) begin
      units = 4'd0;
      tens  = tens + 4'd1;
    end else begin
      units = units + 4'd1;
    end
    return {tens, units};
  endfunction

  // Two-digit BCD decrement, sticks at 00
  function automatic logic [7:0] bcd_dec_floor(input logic [7:0] val);
    bcd_digit_t tens;
    bcd_digit_t units;
    tens  = val[7:4];
    units = val[3:0];
    if (val == 8'h00) return val;
    if (units == 4'd0) begin
      units = 4'd9;
      tens  = tens - 4'd1;
    end else begin
      units = units - 4'd1;
    end
    return {tens, units};
  endfunction

endpackage

// File: rtl/key_debounce.sv
// Four-key debouncer: a key level is accepted after DEBOUNCE_SAMPLES equal
// consecutive samples taken on key_scan_tick; a 0->1 change of the accepted
// level produces a one-clk press strobe.
module key_debounce #(
  parameter int unsigned DEBOUNCE_SAMPLES = 3
) (
  input  logic       clk_in,
  input  logic       clr_n,
  input  logic       key_scan_tick,
  input  logic [3:0] key_in,
  output logic [3:0] press
);

  localparam int unsigned CntW = $clog2(DEBOUNCE_SAMPLES + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_SAMPLES);

  logic [3:0]      sample_q, sample_d;
  logic [3:0]      stable_q, stable_d;
  logic [3:0]      press_q, press_d;
  logic [CntW-1:0] cnt_q [4];
  logic [CntW-1:0] cnt_d [4];

  // Per-key run-length count of equal samples and stable-level update
  always_comb begin
    sample_d = sample_q;
    stable_d = stable_q;
    press_d  = 4'b0;
    cnt_d    = cnt_q;
    if (key_scan_tick) begin
      for (int i = 0; i < 4; i++) begin
        sample_d[i] = key_in[i];
        if (key_in[i] == sample_q[i]) begin
          if (cnt_q[i] < CntMax) cnt_d[i] = cnt_q[i] + 1'b1;
        end else begin
          // A changed sample starts a new run of length one
          cnt_d[i] = CntW'(1);
        end
        if (cnt_d[i] >= CntMax) stable_d[i] = key_in[i];
        press_d[i] = stable_d[i] & ~stable_q[i];
      end
    end
  end

  // Debounce state registers
  always_ff @(posedge clk_in or negedge clr_n) begin
    if (!clr_n) begin
      sample_q <= 4'b0;
      stable_q <= 4'b0;
      press_q  <= 4'b0;
      for (int i = 0; i < 4; i++) cnt_q[i] <= '0;
    end else begin
      sample_q <= sample_d;
      stable_q <= stable_d;
      press_q  <= press_d;
      for (int i = 0; i < 4; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign press = press_q;

endmodule

// File: rtl/whack_round_ctrl.sv
// Round sequencer for the LED/key reaction game: picks a non-repeating random
// target, opens a timed hit window, judges debounced presses and keeps a
// saturating two-digit BCD score.
// Optional feature: define MISS_PENALTY_EN to decrement the score on a miss.
module whack_round_ctrl
  import whack_pkg::*;
#(
  parameter int unsigned ROUNDS           = 20,
  parameter int unsigned TIMEOUT_TICKS    = 2,
  parameter int unsigned DEBOUNCE_SAMPLES = 3,
  parameter logic [7:0]  LFSR_SEED        = 8'hA5
) (
  input  logic       clk_in,
  input  logic       clr_n,
  input  logic       tick_1s,
  input  logic       key_scan_tick,
  input  logic [3:0] key_in,
  input  logic       start,
  output logic [3:0] led_out,
  output logic       hit_pulse,
  output logic       miss_pulse,
  output logic [7:0] score_bcd,
  output logic [6:0] round_cnt,
  output logic       busy,
  output logic       game_over
);

  localparam logic [6:0] RoundsW  = 7'(ROUNDS);
  localparam logic [3:0] TimeoutW = 4'(TIMEOUT_TICKS);

  state_e     state_q, state_d;
  logic [7:0] lfsr_q, lfsr_d;
  logic [1:0] target_q, target_d;
  logic [3:0] timer_q, timer_d;
  logic [7:0] score_q, score_d;
  logic [6:0] round_q, round_d;
  logic       hit_q, hit_d;
  logic       miss_q, miss_d;
  logic [3:0] press;
  logic [1:0] cand;
  logic       judged;
  logic       won;

  key_debounce #(
    .DEBOUNCE_SAMPLES(DEBOUNCE_SAMPLES)
  ) u_key_debounce (
    .clk_in       (clk_in),
    .clr_n        (clr_n),
    .key_scan_tick(key_scan_tick),
    .key_in       (key_in),
    .press        (press)
  );

  // Free-running LFSR, FSM next state, judging and score update
  always_comb begin
    lfsr_d   = {lfsr_q[6:0], ^(lfsr_q & LfsrTaps)};
    state_d  = state_q;
    target_d = target_q;
    timer_d  = timer_q;
    score_d  = score_q;
    round_d  = round_q;
    hit_d    = 1'b0;
    miss_d   = 1'b0;
    judged   = 1'b0;
    won      = 1'b0;
    cand     = lfsr_q[1:0];
    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          score_d = 8'h00;
          round_d = 7'd0;
          state_d = StLoad;
        end
      end
      StLoad: begin
        // Never show the same LED twice in a row
        target_d = (cand == target_q) ? cand + 2'd1 : cand;
        timer_d  = 4'd0;
        state_d  = StWait;
      end
      StWait: begin
        // A press outranks a coincident timeout tick
        if (press != 4'b0) begin
          judged = 1'b1;
          won    = (press == (4'b0001 << target_q));
        end else if (tick_1s) begin
          timer_d = timer_q + 4'd1;
          if (timer_d == TimeoutW) judged = 1'b1;
        end
        if (judged) begin
          state_d = StGap;
          round_d = round_q + 7'd1;
          if (won) begin
            hit_d   = 1'b1;
            score_d = bcd_inc_sat(score_q);
          end else begin
            miss_d  = 1'b1;
`ifdef MISS_PENALTY_EN
            score_d = bcd_dec_floor(score_q);
`else
            score_d = score_q;
`endif
          end
        end
      end
      StGap: begin
        if (tick_1s) state_d = (round_q == RoundsW) ? StDone : StLoad;
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers; reset aborts any game in progress
  always_ff @(posedge clk_in or negedge clr_n) begin
    if (!clr_n) begin
      state_q  <= StIdle;
      lfsr_q   <= LFSR_SEED;
      target_q <= 2'd0;
      timer_q  <= 4'd0;
      score_q  <= 8'h00;
      round_q  <= 7'd0;
      hit_q    <= 1'b0;
      miss_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      lfsr_q   <= lfsr_d;
      target_q <= target_d;
      timer_q  <= timer_d;
      score_q  <= score_d;
      round_q  <= round_d;
      hit_q    <= hit_d;
      miss_q   <= miss_d;
    end
  end

  // Outputs decoded from registered state
  always_comb begin
    led_out    = (state_q == StWait) ? (4'b0001 << target_q) : 4'b0;
    busy       = (state_q == StLoad) || (state_q == StWait) || (state_q == StGap);
    game_over  = (state_q == StDone);
    hit_pulse  = hit_q;
    miss_pulse = miss_q;
    score_bcd  = score_q;
    round_cnt  = round_q;
  end

endmodule

// File: tb/tb_whack_round_ctrl.sv
// Self-checking bench for whack_round_ctrl: BCD helper vectors, a table of
// scripted rounds, hand-written corner sequences and random rounds checked
// against a round-level reference model.
module tb_whack_round_ctrl;
  import whack_pkg::*;

  localparam int unsigned Rounds  = 20;
  localparam int unsigned Timeout = 2;
  localparam int unsigned Deb     = 3;
  localparam logic [7:0]  Seed    = 8'hA5;

  localparam int AHit = 0, AWrong = 1, ADouble = 2, ATimeout = 3, APressTick = 4, AGlitch = 5;

  logic       clk_in = 1'b0;
  logic       clr_n = 1'b0;
  logic       tick_1s = 1'b0;
  logic       key_scan_tick = 1'b0;
  logic [3:0] key_in = 4'b0;
  logic       start = 1'b0;
  logic [3:0] led_out;
  logic       hit_pulse, miss_pulse, busy, game_over;
  logic [7:0] score_bcd;
  logic [6:0] round_cnt;

  always #5 clk_in = ~clk_in;

  whack_round_ctrl #(
    .ROUNDS(Rounds),
    .TIMEOUT_TICKS(Timeout),
    .DEBOUNCE_SAMPLES(Deb),
    .LFSR_SEED(Seed)
  ) dut (
    .clk_in(clk_in),
    .clr_n(clr_n),
    .tick_1s(tick_1s),
    .key_scan_tick(key_scan_tick),
    .key_in(key_in),
    .start(start),
    .led_out(led_out),
    .hit_pulse(hit_pulse),
    .miss_pulse(miss_pulse),
    .score_bcd(score_bcd),
    .round_cnt(round_cnt),
    .busy(busy),
    .game_over(game_over)
  );

  int n_vec = 0;
  int n_fail = 0;

  // Reference model state
  logic [7:0] m_lfsr, m_lfsr_prev;
  int         exp_score, exp_rounds, exp_prev, cur_target;
  logic [3:0] prev_led;
  logic [3:0] led_snap;

  // LFSR model: x^8+x^6+x^5+x^4+1, shifts every clock
  always @(posedge clk_in or negedge clr_n) begin
    if (!clr_n) begin
      m_lfsr      <= Seed;
      m_lfsr_prev <= Seed;
    end else begin
      m_lfsr_prev <= m_lfsr;
      m_lfsr      <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] to_bcd(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  function automatic logic [3:0] oh(input int t);
    return 4'b0001 << t;
  endfunction

  task automatic cyc();
    @(negedge clk_in);
  endtask

  task automatic scan(input int n);
    repeat (n) begin
      key_scan_tick = 1'b1;
      cyc();
      key_scan_tick = 1'b0;
      cyc();
    end
  endtask

  task automatic tick();
    tick_1s = 1'b1;
    cyc();
    tick_1s = 1'b0;
  endtask

  // Wait for the first WAIT cycle and check the shown target
  task automatic wait_target();
    bit         seen = 1'b0;
    logic [1:0] cand;
    int         t;
    for (int i = 0; i < 8 && !seen; i++) begin
      if (led_out != 4'b0) seen = 1'b1;
      else cyc();
    end
    check("target shown", seen, 1'b1);
    if (!seen) return;
    cand = m_lfsr_prev[1:0];
    t = (int'(cand) == exp_prev) ? (int'(cand) + 1) % 4 : int'(cand);
    check("target", led_out, oh(t));
    if (prev_led != 4'b0) check("target repeat", led_out == prev_led, 1'b0);
    exp_prev   = t;
    cur_target = t;
    prev_led   = led_out;
  endtask

  // Wait for a judgement and compare it with the model
  task automatic wait_pulse(input bit exp_hit, input string name);
    bit got = 1'b0;
    for (int i = 0; i < 16 && !got; i++) begin
      if (hit_pulse || miss_pulse) got = 1'b1;
      else cyc();
    end
    check({name, " judged"}, got, 1'b1);
    exp_rounds++;
    if (exp_hit) begin
      if (exp_score < 99) exp_score++;
    end else begin
`ifdef MISS_PENALTY_EN
      if (exp_score > 0) exp_score--;
`endif
    end
    check({name, " hit/miss"}, {hit_pulse, miss_pulse}, {exp_hit, !exp_hit});
    check({name, " score"}, score_bcd, to_bcd(exp_score));
    check({name, " round_cnt"}, round_cnt, 7'(exp_rounds));
    check({name, " gap led/busy"}, {led_out, busy}, {4'b0, 1'b1});
    cyc();
    check({name, " pulse width"}, {hit_pulse, miss_pulse}, 2'b00);
  endtask

  task automatic play(input int action);
    int w;
    case (action)
      AHit: begin
        key_in = oh(cur_target);
        scan(Deb);
        wait_pulse(1'b1, "hit");
      end
      AWrong: begin
        w = (cur_target + 1 + int'($urandom_range(0, 2))) % 4;
        key_in = oh(w);
        scan(Deb);
        wait_pulse(1'b0, "wrong key");
      end
      ADouble: begin
        key_in = oh(cur_target) | oh((cur_target + 2) % 4);
        scan(Deb);
        wait_pulse(1'b0, "two keys");
      end
      ATimeout: begin
        repeat (Timeout - 1) tick();
        check("window open", {hit_pulse, miss_pulse, led_out != 4'b0}, 3'b001);
        tick();
        wait_pulse(1'b0, "timeout");
      end
      APressTick: begin
        repeat (Timeout - 1) tick();
        key_in = oh(cur_target);
        scan(Deb - 1);
        key_scan_tick = 1'b1;
        cyc();
        key_scan_tick = 1'b0;
        tick_1s = 1'b1;
        cyc();
        tick_1s = 1'b0;
        wait_pulse(1'b1, "press+tick");
      end
      AGlitch: begin
        key_in = oh(cur_target);
        scan(Deb - 1);
        key_in = 4'b0;
        scan(Deb);
        check("glitch ignored", {hit_pulse, miss_pulse, led_out}, {2'b00, oh(cur_target)});
        key_in = oh(cur_target);
        scan(Deb);
        wait_pulse(1'b1, "hit after glitch");
      end
      default: ;
    endcase
  endtask

  task automatic finish_round();
    key_in = 4'b0;
    scan(Deb);
    tick();
    if (exp_rounds == int'(Rounds))
      check("game over", {game_over, busy, led_out, score_bcd},
            {1'b1, 1'b0, 4'b0, to_bcd(exp_score)});
    else
      wait_target();
  endtask

  task automatic start_game();
    start = 1'b1;
    cyc();
    start = 1'b0;
    exp_score  = 0;
    exp_rounds = 0;
    check("start clears", {busy, score_bcd, round_cnt, game_over}, {1'b1, 8'h00, 7'd0, 1'b0});
    wait_target();
  endtask

  task automatic reset_model();
    exp_prev   = 0;
    exp_score  = 0;
    exp_rounds = 0;
    prev_led   = 4'b0;
  endtask

  typedef struct {
    int         act;
    logic [7:0] score;
    logic [7:0] score_pen;
    bit         poke;
  } vec_t;

  typedef struct {
    logic [7:0] val;
    logic [7:0] inc;
    logic [7:0] dec;
  } bcd_vec_t;

  initial begin
    vec_t     tbl[8];
    bcd_vec_t bt[7];

    bt[0] = '{8'h00, 8'h01, 8'h00};
    bt[1] = '{8'h09, 8'h10, 8'h08};
    bt[2] = '{8'h10, 8'h11, 8'h09};
    bt[3] = '{8'h19, 8'h20, 8'h18};
    bt[4] = '{8'h90, 8'h91, 8'h89};
    bt[5] = '{8'h98, 8'h99, 8'h97};
    bt[6] = '{8'h99, 8'h99, 8'h98};

    tbl[0] = '{AHit,       8'h01, 8'h01, 1'b0};
    tbl[1] = '{AWrong,     8'h01, 8'h00, 1'b0};
    tbl[2] = '{ADouble,    8'h01, 8'h00, 1'b0};
    tbl[3] = '{ATimeout,   8'h01, 8'h00, 1'b0};
    tbl[4] = '{APressTick, 8'h02, 8'h01, 1'b0};
    tbl[5] = '{AGlitch,    8'h03, 8'h02, 1'b0};
    tbl[6] = '{AHit,       8'h04, 8'h03, 1'b1};
    tbl[7] = '{AWrong,     8'h04, 8'h02, 1'b0};

    reset_model();

    foreach (bt[i]) begin
      check("bcd_inc_sat", bcd_inc_sat(bt[i].val), bt[i].inc);
      check("bcd_dec_floor", bcd_dec_floor(bt[i].val), bt[i].dec);
    end

    // Reset held with active inputs: all outputs stay low
    start = 1'b1;
    key_in = 4'hF;
    tick_1s = 1'b1;
    key_scan_tick = 1'b1;
    repeat (4) begin
      cyc();
      check("outputs in reset",
            {led_out, hit_pulse, miss_pulse, busy, game_over, score_bcd, round_cnt}, '0);
    end
    start = 1'b0;
    key_in = 4'b0;
    tick_1s = 1'b0;
    key_scan_tick = 1'b0;
    cyc();
    clr_n = 1'b1;
    repeat (1 + $urandom_range(0, 5)) cyc();
    check("idle after reset",
          {led_out, hit_pulse, miss_pulse, busy, game_over, score_bcd, round_cnt}, '0);

    // Game 1: scripted rounds, then random ones to the end
    start_game();
    for (int i = 0; i < 8; i++) begin
      if (tbl[i].poke) begin
        led_snap = led_out;
        start = 1'b1;
        cyc();
        start = 1'b0;
        cyc();
        check("start in WAIT ignored", {led_out, round_cnt, score_bcd, hit_pulse, miss_pulse},
              {led_snap, 7'(exp_rounds), to_bcd(exp_score), 2'b00});
      end
      play(tbl[i].act);
`ifdef MISS_PENALTY_EN
      check("table score", score_bcd, tbl[i].score_pen);
`else
      check("table score", score_bcd, tbl[i].score);
`endif
      finish_round();
    end
    for (int r = 8; r < int'(Rounds); r++) begin
      play(int'($urandom_range(0, 5)));
      finish_round();
    end

    // Restart from DONE, all hits
    start_game();
    for (int r = 0; r < int'(Rounds); r++) begin
      play(AHit);
      finish_round();
    end
    check("all hits score", score_bcd, 8'h20);

    // Reset asserted in WAIT
    start_game();
    play(AHit);
    finish_round();
    #2 clr_n = 1'b0;
    #1;
    check("reset in WAIT",
          {led_out, hit_pulse, miss_pulse, busy, game_over, score_bcd, round_cnt}, '0);
    cyc();
    check("no pulse after reset", {hit_pulse, miss_pulse, led_out}, '0);
    key_in = 4'b0;
    clr_n = 1'b1;
    reset_model();
    repeat (1 + $urandom_range(0, 3)) cyc();

    // Random games for target sequence and judging coverage
    for (int g = 0; g < 8; g++) begin
      start_game();
      for (int r = 0; r < int'(Rounds); r++) begin
        play(int'($urandom_range(0, 5)));
        finish_round();
      end
      repeat ($urandom_range(0, 4)) cyc();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
